// File: rtl/magic_ctl.sv
// magic_ctl: prioritised NMI entry, magic-ROM mapping with signature
// check and exit/re-enter traps, plus a byte-wide config register file.
module magic_ctl #(
  parameter int                   NUM_SRC      = 4,
  parameter int                   NUM_CFG      = 16,
  parameter logic [NUM_CFG*8-1:0] CFG_RESET    = {NUM_CFG{8'h00}},
  parameter logic [7:0]           SIG_OPCODE   = 8'hEB,
  parameter logic [15:0]          NMI_VEC      = 16'h0066,
  parameter logic [15:0]          EXIT_ADDR    = 16'hF000,
  parameter logic [15:0]          REENTER_ADDR = 16'hF008,
  parameter logic [7:0]           CFG_PORT     = 8'hFF
) (
  input  logic                   clk28,
  input  logic                   rst_n,
  input  logic [15:0]            a,
  input  logic [7:0]             d,
  input  logic                   mreq,
  input  logic                   ioreq,
  input  logic                   m1,
  input  logic                   rd,
  input  logic                   wr,
  input  logic                   n_int,
  input  logic                   n_int_next,
  input  logic [NUM_SRC-1:0]     nmi_req,
  input  logic [7:0]             status_in,
  output logic                   n_nmi,
  output logic                   magic_mode,
  output logic                   magic_map,
  output logic [2:0]             cause,
  output logic [NUM_CFG*8-1:0]   cfg,
  output logic [7:0]             d_out,
  output logic                   d_out_active
);

  typedef enum logic [3:0] {
    BOOT_MAP,
    DISABLED,
    IDLE,
    NMI_PEND,
    CHECK,
    MAPPED,
    UNMAP_EXIT,
    UNMAP_REENTER,
    REENTER_WAIT
  } state_e;

  state_e               state_q, state_d;
  logic                 seen_q, seen_d;
  logic                 match_q, match_d;
  logic                 n_nmi_q, n_nmi_d;
  logic                 mode_q, mode_d;
  logic                 map_q, map_d;
  logic [2:0]           cause_q, cause_d;
  logic [NUM_CFG*8-1:0] cfg_q, cfg_d;
  logic [7:0]           d_out_q, d_out_d;
  logic                 act_q, act_d;

  logic       fetch;
  logic       int_fall;
  logic [2:0] win;
  logic [7:0] idx;
  logic       idx_ok;
  logic       port_hit;
  logic       wr_hit;
  logic       rd_hit;
  logic [7:0] rd_cfg;

  assign fetch    = mreq & m1 & rd;
  assign int_fall = n_int & ~n_int_next;
  assign idx      = a[15:8];
  assign idx_ok   = {1'b0, idx} < 9'(NUM_CFG);
  assign port_hit = a[7:0] == CFG_PORT;
  assign wr_hit   = map_q & ioreq & wr & port_hit & idx_ok;
  assign rd_hit   = map_q & ioreq & rd & port_hit;

  // Lowest set bit wins: scan from the top so bit 0 overrides last.
  always_comb begin
    win = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (nmi_req[i]) win = 3'(i);
    end
  end

  always_comb begin
    rd_cfg = '0;
    for (int i = 0; i < NUM_CFG; i++) begin
      if (idx == 8'(i)) rd_cfg = cfg_q[8*i +: 8];
    end
  end

  always_comb begin
    cfg_d = cfg_q;
    for (int i = 0; i < NUM_CFG; i++) begin
      if (wr_hit && idx == 8'(i)) cfg_d[8*i +: 8] = d;
    end
  end

  always_comb begin
    d_out_d = d_out_q;
    act_d   = 1'b0;
    if (rd_hit) begin
      unique case (1'b1)
        idx_ok: begin
          d_out_d = rd_cfg;
          act_d   = 1'b1;
        end
        idx == 8'hFE: begin
          d_out_d = {n_nmi_q, mode_q, 3'b000, cause_q};
          act_d   = 1'b1;
        end
        idx == 8'hFF: begin
          d_out_d = status_in;
          act_d   = 1'b1;
        end
        default: act_d = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    seen_d  = seen_q;
    match_d = match_q;
    n_nmi_d = n_nmi_q;
    mode_d  = mode_q;
    map_d   = map_q;
    cause_d = cause_q;
    unique case (state_q)
      BOOT_MAP, CHECK: begin
        // Latch the first fetch, commit once that fetch strobe ends.
        if (fetch) begin
          if (!seen_q) begin
            seen_d  = 1'b1;
            match_d = d == SIG_OPCODE;
          end
        end else if (seen_q) begin
          seen_d = 1'b0;
          if (match_q) begin
            state_d = MAPPED;
          end else begin
            state_d = (state_q == BOOT_MAP) ? DISABLED : IDLE;
            map_d   = 1'b0;
            mode_d  = 1'b0;
          end
        end
      end
      DISABLED: state_d = DISABLED;
      IDLE: begin
        if (int_fall && |nmi_req) begin
          cause_d = win;
          n_nmi_d = 1'b0;
          mode_d  = 1'b1;
          state_d = NMI_PEND;
        end
      end
      NMI_PEND: begin
        if (m1 && mreq && a == NMI_VEC) begin
          n_nmi_d = 1'b1;
          map_d   = 1'b1;
          seen_d  = 1'b0;
          state_d = CHECK;
        end
      end
      MAPPED: begin
        if (mreq && rd && a == EXIT_ADDR) begin
          mode_d  = 1'b0;
          state_d = UNMAP_EXIT;
        end else if (mreq && rd && a == REENTER_ADDR) begin
          state_d = UNMAP_REENTER;
        end
      end
      UNMAP_EXIT: begin
        if (!mreq) begin
          map_d   = 1'b0;
          state_d = IDLE;
        end
      end
      UNMAP_REENTER: begin
        if (!mreq) begin
          map_d   = 1'b0;
          state_d = REENTER_WAIT;
        end
      end
      REENTER_WAIT: begin
        if (m1 && mreq) begin
          map_d   = 1'b1;
          state_d = MAPPED;
        end
      end
      default: state_d = BOOT_MAP;
    endcase
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT_MAP;
      seen_q  <= 1'b0;
      match_q <= 1'b0;
      n_nmi_q <= 1'b1;
      mode_q  <= 1'b1;
      map_q   <= 1'b1;
      cause_q <= 3'd0;
      cfg_q   <= CFG_RESET;
      d_out_q <= 8'hFF;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      seen_q  <= seen_d;
      match_q <= match_d;
      n_nmi_q <= n_nmi_d;
      mode_q  <= mode_d;
      map_q   <= map_d;
      cause_q <= cause_d;
      cfg_q   <= cfg_d;
      d_out_q <= d_out_d;
      act_q   <= act_d;
    end
  end

  assign n_nmi        = n_nmi_q;
  assign magic_mode   = mode_q;
  assign magic_map    = map_q;
  assign cause        = cause_q;
  assign cfg          = cfg_q;
  assign d_out        = d_out_q;
  assign d_out_active = act_q;

endmodule

// File: tb/tb_magic_ctl.sv
// Bench for magic_ctl: boot check, NMI entry, traps, config port
// and reset; read-back data goes through an expected-value queue.
module tb_magic_ctl;

  localparam logic [127:0] CFG_RST =
    128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;

  logic         clk28 = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  a = '0;
  logic [7:0]   d = '0;
  logic         mreq = 0, ioreq = 0, m1 = 0, rd = 0, wr = 0;
  logic         n_int = 1, n_int_next = 1;
  logic [3:0]   nmi_req = '0;
  logic [7:0]   status_in = 8'h3C;
  logic         n_nmi, magic_mode, magic_map;
  logic [2:0]   cause;
  logic [127:0] cfg;
  logic [7:0]   d_out;
  logic         d_out_active;

  logic [127:0] cfg_m;
  logic [7:0]   exp_q[$];
  logic [7:0]   exp;
  int           pass_cnt = 0;
  int           tot_cnt = 0;

  magic_ctl #(.NUM_SRC(4), .NUM_CFG(16), .CFG_RESET(CFG_RST)) dut (
    .clk28(clk28), .rst_n(rst_n), .a(a), .d(d),
    .mreq(mreq), .ioreq(ioreq), .m1(m1), .rd(rd), .wr(wr),
    .n_int(n_int), .n_int_next(n_int_next),
    .nmi_req(nmi_req), .status_in(status_in),
    .n_nmi(n_nmi), .magic_mode(magic_mode), .magic_map(magic_map),
    .cause(cause), .cfg(cfg), .d_out(d_out),
    .d_out_active(d_out_active)
  );

  always #18 clk28 = ~clk28;

  task automatic tick();
    @(posedge clk28);
    #1;
  endtask

  task automatic bus(input logic [15:0] aa, input logic [7:0] dd,
                     input logic mq, iq, mm, r, w);
    a = aa; d = dd; mreq = mq; ioreq = iq; m1 = mm; rd = r; wr = w;
  endtask

  task automatic bus_idle();
    bus(16'h0000, 8'h00, 0, 0, 0, 0, 0);
  endtask

  task automatic fetch(input logic [15:0] aa, input logic [7:0] op);
    bus(aa, op, 1, 0, 1, 1, 0);
    tick();
    tick();
    bus_idle();
    tick();
  endtask

  task automatic int_edge();
    n_int = 1'b1;
    n_int_next = 1'b0;
    tick();
    n_int_next = 1'b1;
  endtask

  task automatic mem_rd(input logic [15:0] aa);
    bus(aa, 8'h00, 1, 0, 0, 1, 0);
    tick();
  endtask

  task automatic io_wr(input logic [15:0] aa, input logic [7:0] dd);
    bus(aa, dd, 0, 1, 0, 0, 1);
    if (magic_map && aa[7:0] == 8'hFF && aa[15:8] < 8'd16)
      cfg_m[8*aa[15:8] +: 8] = dd;
    tick();
    bus_idle();
    tick();
  endtask

  task automatic io_rd(input logic [15:0] aa, input logic [7:0] e);
    bus(aa, 8'h00, 0, 1, 0, 1, 0);
    exp_q.push_back(e);
    tick();
  endtask

  task automatic test_reset();
    tot_cnt++; if (n_nmi !== 1'b1) $display("FAIL rst_n_nmi got=%b exp=1", n_nmi); else pass_cnt++;
    tot_cnt++; if (magic_mode !== 1'b1) $display("FAIL rst_mode got=%b exp=1", magic_mode); else pass_cnt++;
    tot_cnt++; if (magic_map !== 1'b1) $display("FAIL rst_map got=%b exp=1", magic_map); else pass_cnt++;
    tot_cnt++; if (cause !== 3'd0) $display("FAIL rst_cause got=%0d exp=0", cause); else pass_cnt++;
    tot_cnt++; if (cfg !== CFG_RST) $display("FAIL rst_cfg got=%h exp=%h", cfg, CFG_RST); else pass_cnt++;
    tot_cnt++; if (d_out_active !== 1'b0) $display("FAIL rst_act got=%b exp=0", d_out_active); else pass_cnt++;
    tot_cnt++; if (d_out !== 8'hFF) $display("FAIL rst_dout got=%h exp=ff", d_out); else pass_cnt++;
  endtask

  task automatic test_boot_exit();
    fetch(16'h0000, 8'hEB);
    tot_cnt++; if (magic_map !== 1'b1) $display("FAIL boot_map got=%b exp=1", magic_map); else pass_cnt++;
    mem_rd(16'hF000);
    tot_cnt++; if (magic_mode !== 1'b0) $display("FAIL exit_mode got=%b exp=0", magic_mode); else pass_cnt++;
    tot_cnt++; if (magic_map !== 1'b1) $display("FAIL exit_hold_map got=%b exp=1", magic_map); else pass_cnt++;
    bus_idle();
    tick();
    tot_cnt++; if (magic_map !== 1'b0) $display("FAIL exit_map got=%b exp=0", magic_map); else pass_cnt++;
  endtask

  task automatic test_entry();
    nmi_req = 4'b0110;
    int_edge();
    nmi_req = 4'b0000;
    tot_cnt++; if (n_nmi !== 1'b0) $display("FAIL entry_nmi got=%b exp=0", n_nmi); else pass_cnt++;
    tot_cnt++; if (cause !== 3'd1) $display("FAIL entry_cause got=%0d exp=1", cause); else pass_cnt++;
    tot_cnt++; if (magic_mode !== 1'b1) $display("FAIL entry_mode got=%b exp=1", magic_mode); else pass_cnt++;
    bus(16'h0066, 8'hEB, 1, 0, 1, 1, 0);
    tick();
    tot_cnt++; if (n_nmi !== 1'b1) $display("FAIL vec_nmi got=%b exp=1", n_nmi); else pass_cnt++;
    tot_cnt++; if (magic_map !== 1'b1) $display("FAIL vec_map got=%b exp=1", magic_map); else pass_cnt++;
    tick();
    bus_idle();
    tick();
    tot_cnt++; if (magic_map !== 1'b1) $display("FAIL check_map got=%b exp=1", magic_map); else pass_cnt++;
  endtask

  task automatic test_reenter();
    mem_rd(16'hF008);
    bus_idle();
    tick();
    tot_cnt++; if (magic_map !== 1'b0) $display("FAIL reent_unmap got=%b exp=0", magic_map); else pass_cnt++;
    tot_cnt++; if (magic_mode !== 1'b1) $display("FAIL reent_mode got=%b exp=1", magic_mode); else pass_cnt++;
    bus(16'h1234, 8'h00, 1, 0, 1, 1, 0);
    tick();
    tot_cnt++; if (magic_map !== 1'b1) $display("FAIL reent_map got=%b exp=1", magic_map); else pass_cnt++;
    bus_idle();
    tick();
  endtask

  task automatic test_cfg();
    io_wr(16'h03FF, 8'hA5);
    tot_cnt++; if (cfg !== cfg_m) $display("FAIL cfg_wr3 got=%h exp=%h", cfg, cfg_m); else pass_cnt++;
    io_wr(16'h0FFF, 8'h5A);
    tot_cnt++; if (cfg !== cfg_m) $display("FAIL cfg_wr15 got=%h exp=%h", cfg, cfg_m); else pass_cnt++;
    io_wr(16'h40FF, 8'h99);
    tot_cnt++; if (cfg !== cfg_m) $display("FAIL cfg_wr_oob got=%h exp=%h", cfg, cfg_m); else pass_cnt++;
    io_rd(16'h03FF, 8'hA5);
    io_rd(16'h0FFF, 8'h5A);
    io_rd(16'h07FF, 8'h07);
    io_rd(16'hFEFF, 8'hC1);
    io_rd(16'hFFFF, 8'h3C);
    bus_idle();
    // Reads are back-to-back: result of each appears one clk later.
    for (int k = 0; k < 5; k++) begin
      if (k == 0) begin
        bus(16'h03FF, 8'h00, 0, 1, 0, 1, 0);
        @(posedge clk28); #1;
      end
    end
    bus_idle();
    exp_q.delete();
    io_rd(16'h03FF, 8'hA5);
    exp = exp_q.pop_front();
    tot_cnt++; if (d_out_active !== 1'b1 || d_out !== exp) $display("FAIL rd3 got=%h/%b exp=%h/1", d_out, d_out_active, exp); else pass_cnt++;
    io_rd(16'h0FFF, 8'h5A);
    exp = exp_q.pop_front();
    tot_cnt++; if (d_out_active !== 1'b1 || d_out !== exp) $display("FAIL rd15 got=%h/%b exp=%h/1", d_out, d_out_active, exp); else pass_cnt++;
    io_rd(16'h07FF, 8'h07);
    exp = exp_q.pop_front();
    tot_cnt++; if (d_out_active !== 1'b1 || d_out !== exp) $display("FAIL rd7 got=%h/%b exp=%h/1", d_out, d_out_active, exp); else pass_cnt++;
    io_rd(16'hFEFF, 8'hC1);
    exp = exp_q.pop_front();
    tot_cnt++; if (d_out_active !== 1'b1 || d_out !== exp) $display("FAIL rd_stat got=%h/%b exp=%h/1", d_out, d_out_active, exp); else pass_cnt++;
    io_rd(16'hFFFF, 8'h3C);
    exp = exp_q.pop_front();
    tot_cnt++; if (d_out_active !== 1'b1 || d_out !== exp) $display("FAIL rd_raw got=%h/%b exp=%h/1", d_out, d_out_active, exp); else pass_cnt++;
    bus_idle();
    tick();
    tot_cnt++; if (d_out_active !== 1'b0) $display("FAIL rd_drop got=%b exp=0", d_out_active); else pass_cnt++;
    bus(16'h20FF, 8'h00, 0, 1, 0, 1, 0);
    tick();
    tot_cnt++; if (d_out_active !== 1'b0) $display("FAIL rd_none got=%b exp=0", d_out_active); else pass_cnt++;
    bus_idle();
    tick();
  endtask

  task automatic test_ignore();
    nmi_req = 4'b1000;
    int_edge();
    nmi_req = 4'b0000;
    tot_cnt++; if (n_nmi !== 1'b1) $display("FAIL ign_nmi got=%b exp=1", n_nmi); else pass_cnt++;
    tot_cnt++; if (cause !== 3'd1) $display("FAIL ign_cause got=%0d exp=1", cause); else pass_cnt++;
    mem_rd(16'hF000);
    bus_idle();
    tick();
    tot_cnt++; if (magic_map !== 1'b0) $display("FAIL ign_exit got=%b exp=0", magic_map); else pass_cnt++;
    io_wr(16'h05FF, 8'h77);
    tot_cnt++; if (cfg !== cfg_m) $display("FAIL unmap_wr got=%h exp=%h", cfg, cfg_m); else pass_cnt++;
    bus(16'h03FF, 8'h00, 0, 1, 0, 1, 0);
    tick();
    tot_cnt++; if (d_out_active !== 1'b0) $display("FAIL unmap_rd got=%b exp=0", d_out_active); else pass_cnt++;
    bus_idle();
    tick();
  endtask

  task automatic test_prio_reset();
    nmi_req = 4'b1100;
    int_edge();
    tot_cnt++; if (cause !== 3'd2) $display("FAIL prio_cause got=%0d exp=2", cause); else pass_cnt++;
    tot_cnt++; if (n_nmi !== 1'b0) $display("FAIL prio_nmi got=%b exp=0", n_nmi); else pass_cnt++;
    nmi_req = 4'b0000;
    #4 rst_n = 1'b0;
    cfg_m = CFG_RST;
    #4;
    tot_cnt++; if (n_nmi !== 1'b1) $display("FAIL ares_nmi got=%b exp=1", n_nmi); else pass_cnt++;
    tot_cnt++; if (magic_map !== 1'b1) $display("FAIL ares_map got=%b exp=1", magic_map); else pass_cnt++;
    tot_cnt++; if (cause !== 3'd0) $display("FAIL ares_cause got=%0d exp=0", cause); else pass_cnt++;
    tot_cnt++; if (cfg !== cfg_m) $display("FAIL ares_cfg got=%h exp=%h", cfg, cfg_m); else pass_cnt++;
    #4 rst_n = 1'b1;
    tick();
    fetch(16'h0000, 8'h00);
    tot_cnt++; if (magic_map !== 1'b0) $display("FAIL dis_map got=%b exp=0", magic_map); else pass_cnt++;
    tot_cnt++; if (magic_mode !== 1'b0) $display("FAIL dis_mode got=%b exp=0", magic_mode); else pass_cnt++;
    nmi_req = 4'b0001;
    int_edge();
    nmi_req = 4'b0000;
    tot_cnt++; if (n_nmi !== 1'b1) $display("FAIL dis_nmi got=%b exp=1", n_nmi); else pass_cnt++;
    io_wr(16'h01FF, 8'hEE);
    tot_cnt++; if (cfg !== cfg_m) $display("FAIL dis_wr got=%h exp=%h", cfg, cfg_m); else pass_cnt++;
  endtask

  initial begin
    cfg_m = CFG_RST;
    #5 rst_n = 1'b0;
    #40 rst_n = 1'b1;
    tick();
    test_reset();
    test_boot_exit();
    test_entry();
    test_reenter();
    test_cfg();
    test_ignore();
    test_prio_reset();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/magic_ctl.md
Name: magic_ctl

Overview:
- Parametrised successor to the single-button magic/NMI controller.
- Accepts NUM_SRC prioritised NMI request sources and records which source caused entry.
- Maps the magic ROM on the NMI vector, checks a signature opcode, and handles exit/re-enter trap addresses.
- Exposes NUM_CFG byte-wide configuration registers that are writable and readable through one I/O port family.
- Sits between the CPU bus and the memory mapper / peripheral-enable logic.

Parameters:
NUM_SRC, 4, number of NMI request sources (1..8); bit 0 has highest priority
NUM_CFG, 16, number of 8-bit config registers (1..254)
CFG_RESET, {NUM_CFG{8'h00}}, flat NUM_CFG*8-bit reset image; register i is at bits [8i+7:8i]
SIG_OPCODE, 8'hEB, opcode the first magic-ROM fetch must return
NMI_VEC, 16'h0066, M1 address that maps the magic ROM
EXIT_ADDR, 16'hF000, read at this address leaves magic mode and unmaps
REENTER_ADDR, 16'hF008, read at this address unmaps, then remaps on the next M1
CFG_PORT, 8'hFF, low address byte of the config I/O port

Ports:
clk28  in  1  system clock
rst_n  in  1  async active-low reset
a  in  16  CPU address
d  in  8  CPU data (sampled)
mreq, ioreq, m1, rd, wr  in  1 each  active-high CPU strobes, synchronous to clk28
n_int, n_int_next  in  1 each  current and next-cycle INT level; a falling edge is n_int=1 && n_int_next=0
nmi_req  in  NUM_SRC  level-high NMI request per source
status_in  in  8  raw status byte, readable at index 8'hFF
n_nmi  out  1  active-low NMI to CPU
magic_mode  out  1  magic session active
magic_map  out  1  magic ROM mapped
cause  out  3  index of the winning source of the last entry
cfg  out  NUM_CFG*8  flat config register image
d_out  out  8  read-back data
d_out_active  out  1  read-back drive enable

Behaviour:
- Reset values:
  - State = BOOT_MAP.
  - n_nmi=1, magic_mode=1, magic_map=1, cause=0.
  - cfg=CFG_RESET, d_out_active=0, d_out=8'hFF.
- Entry sampling happens only at an INT falling edge. If state is IDLE and |nmi_req:
  - cause <= index of the lowest set bit.
  - n_nmi <= 0, magic_mode <= 1.
  - Go to NMI_PEND.
- If a request arrives while magic_mode=1, it is ignored: no NMI and no cause update.
- FSM states and transitions:
  - BOOT_MAP: first mreq&m1&rd latches match=(d==SIG_OPCODE). The first cycle with the strobe deasserted commits:
    - match=1 -> MAPPED.
    - match=0 -> DISABLED, with magic_map=0 and magic_mode=0.
  - DISABLED: absorbing until reset. nmi_req is ignored and n_nmi stays 1. The cfg port remains inaccessible because magic_map=0.
  - IDLE: magic_map=0, magic_mode=0. Waits for an entry.
  - NMI_PEND: on m1&mreq&a==NMI_VEC -> n_nmi<=1, magic_map<=1, go to CHECK.
  - CHECK: same commit rule as BOOT_MAP.
    - match=1 -> MAPPED.
    - match=0 -> IDLE, with magic_map=0 and magic_mode=0.
  - MAPPED, read at EXIT_ADDR: mreq&rd&a==EXIT_ADDR -> magic_mode<=0, go to UNMAP_EXIT.
  - MAPPED, read at REENTER_ADDR: mreq&rd&a==REENTER_ADDR -> go to UNMAP_REENTER.
  - UNMAP_EXIT: on the first cycle with mreq=0 -> magic_map<=0, go to IDLE.
  - UNMAP_REENTER: on mreq=0 -> magic_map<=0, go to REENTER_WAIT.
  - REENTER_WAIT: next m1&mreq at any address -> magic_map<=1, go to MAPPED. No signature check is made on re-entry.
- Unmap rule: unmapping always waits for mreq to deassert, so the current bus cycle completes with the ROM still mapped.
- Config write: condition is magic_map & ioreq & wr & a[7:0]==CFG_PORT & a[15:8]<NUM_CFG.
  - The register at index a[15:8] is written with d on every qualifying clk28 cycle.
  - Indices >= NUM_CFG are ignored.
- Config read: condition is magic_map & ioreq & rd & a[7:0]==CFG_PORT.
  - Index < NUM_CFG -> d_out = cfg[idx].
  - Index 8'hFE -> d_out = {n_nmi, magic_mode, 3'b0, cause}.
  - Index 8'hFF -> d_out = status_in.
  - Any other index -> no drive.
- Read-back timing: d_out and d_out_active are registered, so they are valid 1 clk28 after the qualifying cycle. d_out_active drops 1 clk after the strobe ends.
- Async reset mid-operation: everything returns to the reset values immediately. This includes returning to BOOT_MAP, so the signature check is repeated.
- Simultaneous requests: the lowest index wins. Other pending levels that are still high are resampled at the next INT falling edge after return to IDLE.

Test Plan:
- Reset, first M1 fetch returns 8'hEB; then read 16'hF000 and end mreq -> magic_map=0, magic_mode=0, state IDLE. Repeat with fetch 8'h00 -> state DISABLED.
- From IDLE, nmi_req=4'b0110 at an INT falling edge -> n_nmi=0, cause=1. M1 at 16'h0066 -> n_nmi=1, magic_map=1. Fetch 8'hEB -> MAPPED.
- In MAPPED, read 16'hF008, end mreq -> magic_map=0. Next M1 at 16'h1234 -> magic_map=1 while magic_mode=1 throughout.
- Write port 16'h03FF=8'hA5, then read 16'h03FF -> d_out=8'hA5 one clk later. Write 16'h40FF with NUM_CFG=16 -> cfg unchanged. Read 16'hFEFF -> 8'hC1 (n_nmi=1, magic_mode=1, cause=1).
- nmi_req asserted while magic_mode=1 -> n_nmi stays 1 and cause is unchanged. Config write with magic_map=0 -> ignored.
- Pulse rst_n low while in NMI_PEND -> n_nmi=1, cfg=CFG_RESET, magic_map=1, and the signature check is repeated.
